pc_sequencer: RTL and testbench

Program-counter and fetch sequencer for the KGP-RISC core; the receiving end of the branch unit's redirect interface (PCSrc/exNPC). It holds the PC and issues single-outstanding instruction-memory reads. It applies taken-branch, call and return redirects, squashing wrong-path fetches. It keeps a hardware return-address stack so that `return` no longer depends on a combinational `ra`.

---
 rtl/kgp_pkg.sv | 33 +++
 rtl/return_addr_stack.sv | 56 +++++
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// kgp_pkg: shared definitions for the KGP-RISC fetch path.
//   - default PC / instruction / return-stack sizes
//   - pc_seq_state_t: fetch sequencer state encoding
//   - opcode / function-code constants shared with the branch unit
package kgp_pkg;

   localparam int unsigned KGP_PC_W      = 10;
   localparam int unsigned KGP_INSTR_W   = 32;
   localparam int unsigned KGP_RAS_DEPTH = 8;

   typedef enum logic [1:0] {
      StRst  = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StHold = 2'd3
   } pc_seq_state_t;

   // Major opcodes and branch function codes, as decoded by the branch unit.
   localparam logic [5:0] OPC_ALU    = 6'h00;
   localparam logic [5:0] OPC_ALUI   = 6'h01;
   localparam logic [5:0] OPC_MEM    = 6'h02;
   localparam logic [5:0] OPC_BRANCH = 6'h03;

   localparam logic [4:0] FC_B    = 5'h00;
   localparam logic [4:0] FC_BL   = 5'h01; // call: link to return stack
   localparam logic [4:0] FC_BCY  = 5'h02;
   localparam logic [4:0] FC_BNCY = 5'h03;
   localparam logic [4:0] FC_BR   = 5'h04; // return through ra
   localparam logic [4:0] FC_BLTZ = 5'h05;
   localparam logic [4:0] FC_BZ   = 5'h06;
   localparam logic [4:0] FC_BNZ  = 5'h07;

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack.
//   clk, rst_n   : clock, synchronous active-low reset (empties the stack)
//   push         : write data_in as the new top
//   pop          : discard the top (ignored when empty)
//   data_in      : return address to push
//   top          : current top entry (meaningless when empty)
//   empty, full  : occupancy flags
// Pushing onto a full stack wraps the pointer and overwrites the oldest
// entry, so the most recent DEPTH return addresses are always kept.
module return_addr_stack #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    sp_q;   // next free slot; top lives at sp_q-1
   logic [AW:0]      cnt_q;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW + 1)'(DEPTH));
   assign top   = mem_q[sp_q - AW'(1)];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else if (push) begin
         sp_q <= sp_q + AW'(1);
         if (!full) begin
            cnt_q <= cnt_q + (AW + 1)'(1);
         end
      end else if (pop && !empty) begin
         sp_q  <= sp_q - AW'(1);
         cnt_q <= cnt_q - (AW + 1)'(1);
      end
   end

   // Storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[sp_q] <= data_in;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: KGP-RISC program counter and single-outstanding fetch sequencer.
//   clk, rst_n          : clock, synchronous active-low reset
//   redirect/redirect_pc: branch unit redirect and target
//   is_call/is_ret      : qualify a redirect as call (push) / return (pop)
//   stall               : decode not ready, hold presented instruction
//   imem_req/imem_addr  : one-cycle read request to instruction memory
//   imem_valid/imem_data: read response (one or more cycles after request)
//   instr/instr_pc/instr_valid : registered instruction presented to decode
//   ras_overflow/ras_underflow : sticky return-stack error flags
// Build option: define PC_SEQ_RAS_EN to include the return-address stack;
// without it calls/returns are plain redirects and the flags stay 0.
module pc_sequencer
   import kgp_pkg::*;
#(
   parameter int unsigned PC_W      = KGP_PC_W,
   parameter int unsigned INSTR_W   = KGP_INSTR_W,
   parameter int unsigned RAS_DEPTH = KGP_RAS_DEPTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               is_call,
   input  logic               is_ret,
   input  logic               stall,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic               ras_overflow,
   output logic               ras_underflow
);

   pc_seq_state_t      state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               squash_q, squash_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
   logic               valid_q, valid_d;
   logic               req_q, req_d;
   logic [PC_W-1:0]    addr_q, addr_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               take;
   logic [PC_W-1:0]    target;

   assign take = redirect && (state_q != StRst);

`ifdef PC_SEQ_RAS_EN
   logic            do_call, do_ret, ras_pop, ras_empty, ras_full;
   logic [PC_W-1:0] ras_top;

   // A combined call+return is treated as a return.
   assign do_ret  = take & is_ret;
   assign do_call = take & is_call & ~is_ret;
   assign ras_pop = do_ret & ~ras_empty;
   assign target  = ras_pop ? ras_top : redirect_pc;
   assign ovf_d   = ovf_q | (do_call & ras_full);
   assign unf_d   = unf_q | (do_ret & ras_empty);

   return_addr_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (PC_W)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (do_call),
      .pop     (ras_pop),
      .data_in (instr_pc_q + PC_W'(1)),
      .top     (ras_top),
      .empty   (ras_empty),
      .full    (ras_full)
   );
`else
   logic unused_ras;

   assign unused_ras = ^{is_call, is_ret, RAS_DEPTH[0]};
   assign target     = redirect_pc;
   assign ovf_d      = 1'b0;
   assign unf_d      = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      squash_d   = squash_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;

      case (state_q)
         StRst: begin
            state_d = StReq;
            pc_d    = '0;
         end
         StReq: begin
            state_d = StWait;
         end
         StWait: begin
            if (imem_valid) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = StReq;
               end else begin
                  instr_d    = imem_data;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  pc_d       = pc_q + PC_W'(1);
                  state_d    = StHold;
               end
            end
         end
         StHold: begin
            if (!stall) begin
               valid_d = 1'b0;
               state_d = StReq;
            end
         end
         default: begin
            state_d = StRst;
         end
      endcase

      // Redirect wins over everything. A request issued this cycle (REQ) or
      // still unanswered (WAIT) leaves a response in flight that must be
      // swallowed before the next request goes out.
      if (take) begin
         pc_d    = target;
         valid_d = 1'b0;
         if ((state_q == StReq) || ((state_q == StWait) && !imem_valid)) begin
            squash_d = 1'b1;
            state_d  = StWait;
         end else begin
            squash_d = 1'b0;
            state_d  = StReq;
         end
      end

      req_d  = (state_d == StReq);
      addr_d = req_d ? pc_d : addr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StRst;
         pc_q       <= '0;
         squash_q   <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         squash_q   <= squash_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign imem_req      = req_q;
   assign imem_addr     = addr_q;
   assign instr         = instr_q;
   assign instr_pc      = instr_pc_q;
   assign instr_valid   = valid_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Expected fetch addresses are queued as stimulus is applied and compared
// against imem_addr / instr_pc as the DUT produces them. A behavioural
// memory answers each request after a programmable latency.
module tb_pc_sequencer;

   localparam int unsigned PC_W      = 10;
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned RAS_DEPTH = 8;
`ifdef PC_SEQ_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               is_call;
   logic               is_ret;
   logic               stall;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;
   logic               instr_valid;
   logic               ras_overflow;
   logic               ras_underflow;

   pc_sequencer #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .is_call       (is_call),
      .is_ret        (is_ret),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_valid    (imem_valid),
      .imem_data     (imem_data),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [PC_W-1:0] rpc;
      logic            call;
      logic            ret;
      logic [PC_W-1:0] exp_addr;
      logic            exp_ovf;
      logic            exp_unf;
   } vec_t;

   vec_t            vecs[$];
   logic [PC_W-1:0] exp_req_q[$];
   logic [PC_W-1:0] exp_ins_q[$];
   int              n_vec = 0;
   int              n_err = 0;
   int              n_instr = 0;
   int              lat = 1;
   int              pend = 0;
   logic [PC_W-1:0] paddr = '0;
   logic            vprev = 1'b0;

   function automatic logic [INSTR_W-1:0] memword(input logic [PC_W-1:0] a);
      return 32'hA500_0000 | {12'h000, a, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   // One clock: sample 1 time unit after the edge, score outputs, run memory.
   task automatic tick();
      logic [PC_W-1:0] e;
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
         if (exp_req_q.size() == 0) begin
            miss($sformatf("unexpected_req addr 0x%0h", imem_addr));
         end else begin
            e = exp_req_q.pop_front();
            chk("imem_addr", 32'(imem_addr), 32'(e));
            exp_ins_q.push_back(e);
         end
      end
      if (instr_valid === 1'b1 && !vprev) begin
         n_instr++;
         if (exp_ins_q.size() == 0) begin
            miss($sformatf("unexpected_instr pc 0x%0h", instr_pc));
         end else begin
            e = exp_ins_q.pop_front();
            chk("instr_pc", 32'(instr_pc), 32'(e));
            chk("instr", instr, memword(e));
         end
      end
      vprev = (instr_valid === 1'b1);
      imem_valid = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            imem_valid = 1'b1;
            imem_data  = memword(paddr);
         end
      end
      if (imem_req === 1'b1) begin
         pend  = lat;
         paddr = imem_addr;
      end
   endtask

   task automatic wait_instr(input int budget);
      int start;
      start = n_instr;
      for (int c = 0; c < budget && n_instr == start; c++) begin
         tick();
      end
      if (n_instr == start) begin
         miss("wait_instr_timeout");
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_imem_req"}, 32'(imem_req), 0);
      chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_instr_pc"}, 32'(instr_pc), 0);
      chk({tag, "_instr_valid"}, 32'(instr_valid), 0);
      chk({tag, "_ovf"}, 32'(ras_overflow), 0);
      chk({tag, "_unf"}, 32'(ras_underflow), 0);
   endtask

   // Redirect from HOLD; the request with the target must follow next cycle.
   task automatic apply_vec(input vec_t v);
      redirect    = 1'b1;
      redirect_pc = v.rpc;
      is_call     = v.call;
      is_ret      = v.ret;
      exp_req_q.push_back(v.exp_addr);
      tick();
      redirect = 1'b0;
      is_call  = 1'b0;
      is_ret   = 1'b0;
      chk({v.name, "_req"}, 32'(imem_req), 1);
      chk({v.name, "_ovf"}, 32'(ras_overflow), 32'(v.exp_ovf));
      chk({v.name, "_unf"}, 32'(ras_underflow), 32'(v.exp_unf));
      wait_instr(20);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   vc;
      vec_t v;

      // Vector table: redirects, calls and returns issued from HOLD.
      vecs.push_back('{"redir", 10'h010, 1'b0, 1'b0, 10'h010, 1'b0, 1'b0});
      vecs.push_back('{"call1", 10'h100, 1'b1, 1'b0, 10'h100, 1'b0, 1'b0});
      vecs.push_back('{"call2", 10'h180, 1'b1, 1'b0, 10'h180, 1'b0, 1'b0});
      vecs.push_back('{"callret", 10'h3FF, 1'b1, 1'b1,
                       RAS_EN ? 10'h101 : 10'h3FF, 1'b0, 1'b0});
      vecs.push_back('{"ret", 10'h3FF, 1'b0, 1'b1,
                       RAS_EN ? 10'h011 : 10'h3FF, 1'b0, 1'b0});
      for (int i = 0; i < int'(RAS_DEPTH) + 1; i++) begin
         v.name     = $sformatf("nest%0d", i);
         v.rpc      = PC_W'(10'h200 + 16 * i);
         v.call     = 1'b1;
         v.ret      = 1'b0;
         v.exp_addr = v.rpc;
         v.exp_ovf  = RAS_EN && (i == int'(RAS_DEPTH));
         v.exp_unf  = 1'b0;
         vecs.push_back(v);
      end
      vecs.push_back('{"ret_ovf", 10'h3FF, 1'b0, 1'b1,
                       RAS_EN ? 10'h271 : 10'h3FF, RAS_EN, 1'b0});

      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      is_call     = 1'b0;
      is_ret      = 1'b0;
      stall       = 1'b1;
      imem_valid  = 1'b0;
      imem_data   = '0;

      repeat (3) tick();
      chk_zero("reset");

      // Sequential fetch, 1-cycle memory, no stall.
      for (int a = 0; a < 4; a++) exp_req_q.push_back(PC_W'(a));
      rst_n = 1'b1;
      stall = 1'b0;
      tick();
      chk("req_after_reset", 32'(imem_req), 1);
      vc = 0;
      for (int c = 0; c < 40 && n_instr < 4; c++) begin
         tick();
         if (instr_valid === 1'b1) vc++;
      end
      stall = 1'b1;
      chk("seq_fetch_count", 32'(n_instr), 4);
      chk("valid_cycles", 32'(vc), 4);

      // Stall in HOLD for 5 cycles.
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("stall_valid", 32'(instr_valid), 1);
         chk("stall_pc", 32'(instr_pc), 3);
         chk("stall_instr", instr, memword(10'h003));
      end
      exp_req_q.push_back(10'h004);
      stall = 1'b0;
      tick();
      stall = 1'b1;
      chk("stall_release_req", 32'(imem_req), 1);
      wait_instr(20);

      // Redirect while a 3-cycle read is outstanding.
      lat = 3;
      exp_req_q.push_back(10'h005);
      stall = 1'b0;
      tick();
      stall = 1'b1;
      tick();
      redirect    = 1'b1;
      redirect_pc = 10'h040;
      void'(exp_ins_q.pop_back());
      exp_req_q.push_back(10'h040);
      tick();
      redirect = 1'b0;
      chk("squash_no_req", 32'(imem_req), 0);
      tick();
      chk("squash_stale_valid", 32'(instr_valid), 0);
      tick();
      chk("req_after_squash", 32'(imem_req), 1);
      chk("squash_dropped", 32'(instr_valid), 0);
      wait_instr(20);
      lat = 1;

      // Table-driven redirects / calls / returns.
      foreach (vecs[i]) begin
         if (i == 3) begin
            // Call/return qualifiers without redirect must do nothing.
            is_call = 1'b1;
            is_ret  = 1'b1;
            repeat (2) tick();
            is_call = 1'b0;
            is_ret  = 1'b0;
            chk("qual_no_redirect_req", 32'(imem_req), 0);
            chk("qual_no_redirect_valid", 32'(instr_valid), 1);
         end
         apply_vec(vecs[i]);
      end

      // One-cycle reset while a 2-cycle read is outstanding.
      lat = 2;
      exp_req_q.push_back(RAS_EN ? 10'h272 : 10'h000);
      stall = 1'b0;
      tick();
      stall = 1'b1;
      tick();
      rst_n = 1'b0;
      exp_req_q.delete();
      exp_ins_q.delete();
      tick();
      chk_zero("midreset");
      rst_n = 1'b1;
      lat   = 1;
      exp_req_q.push_back(10'h000);
      tick();
      chk("restart_req", 32'(imem_req), 1);
      chk("restart_late_valid_ignored", 32'(instr_valid), 0);
      wait_instr(20);

      // Return on an empty stack falls back to redirect_pc.
      v = '{"ret_empty", 10'h055, 1'b0, 1'b1, 10'h055, 1'b0, RAS_EN};
      apply_vec(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
